// File: rtl/sdram_mm_arbiter_if.sv
// sdram_mm_arbiter_if
//   Avalon-MM command/response bundle used for both arbiter master ports and
//   the shared SDRAM slave port.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid.
//   slave modport  : the mirror image.
interface sdram_mm_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
) ();

  localparam int unsigned BeW = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BeW-1:0]    byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_mm_arbiter.sv
// sdram_mm_arbiter
//   Shares one SDRAM Avalon-MM slave between two masters (m0: PCIe bridge,
//   m1: image pipeline). Round-robin grant, up to QUANTUM accepted transfers
//   per tenure, and outstanding reads are drained before ownership changes so
//   read data always returns to the master that issued it.
// Ports
//   clk_clk      in   system clock
//   reset_reset  in   synchronous, active-high reset
//   m0, m1       slave modport   master-side command in, waitrequest/readdata out
//   s            master modport  command to SDRAM slave, waitrequest/readdata in
//   arb_err      out  sticky: readdatavalid arrived with no read outstanding
module sdram_mm_arbiter #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned QUANTUM  = 16,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  sdram_mm_arbiter_if.slave  m0,
  sdram_mm_arbiter_if.slave  m1,
  sdram_mm_arbiter_if.master s,
  output logic               arb_err
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned QcntW = $clog2(QUANTUM + 1);
  localparam int unsigned PendW = $clog2(MAX_PEND + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOwn   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]       r_state;
  logic             r_own;
  logic             r_last;
  logic [QcntW-1:0] r_qcnt;
  logic [PendW-1:0] r_pend;
  logic             r_arb_err;

  logic [1:0]       w_state_d;
  logic             w_own_d;
  logic             w_last_d;
  logic [QcntW-1:0] w_qcnt_d;
  logic [PendW-1:0] w_pend_d;

  logic              w_req0;
  logic              w_req1;
  logic              w_own_rd;
  logic              w_own_wr;
  logic              w_own_req;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic [BeW-1:0]    w_cmd_be;
  logic              w_mask;
  logic              w_s_read;
  logic              w_s_write;
  logic              w_wait0;
  logic              w_wait1;
  logic              w_accept;
  logic              w_acc_rd;
  logic              w_rdv_ok;

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;

  // Owner's command is steered to the slave; the mux is harmless outside OWN
  // because read/write are forced low there.
  assign w_own_rd    = r_own ? m1.read       : m0.read;
  assign w_own_wr    = r_own ? m1.write      : m0.write;
  assign w_own_req   = w_own_rd | w_own_wr;
  assign w_cmd_addr  = r_own ? m1.address    : m0.address;
  assign w_cmd_wdata = r_own ? m1.writedata  : m0.writedata;
  assign w_cmd_be    = r_own ? m1.byteenable : m0.byteenable;

  // Read window full: hold off the next command unless a return frees a slot
  // in this same cycle.
  assign w_mask = (r_pend == PendW'(MAX_PEND)) & ~s.readdatavalid;

  always_comb begin
    w_s_read  = 1'b0;
    w_s_write = 1'b0;
    w_wait0   = 1'b1;
    w_wait1   = 1'b1;
    if (r_state == StOwn && !w_mask) begin
      w_s_read  = w_own_rd;
      w_s_write = w_own_wr;
      if (r_own) begin
        w_wait1 = s.waitrequest;
      end else begin
        w_wait0 = s.waitrequest;
      end
    end
  end

  assign w_accept = (w_s_read | w_s_write) & ~s.waitrequest;
  assign w_acc_rd = w_accept & w_s_read;
  // Returns with nothing outstanding are dropped (and flagged).
  assign w_rdv_ok = s.readdatavalid & (r_pend != '0);

  always_comb begin
    w_pend_d = r_pend;
    unique case ({w_acc_rd, w_rdv_ok})
      2'b10:   w_pend_d = r_pend + 1'b1;
      2'b01:   w_pend_d = r_pend - 1'b1;
      default: w_pend_d = r_pend;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_own_d   = r_own;
    w_last_d  = r_last;
    w_qcnt_d  = r_qcnt;
    unique case (r_state)
      StIdle: begin
        if (w_req0 | w_req1) begin
          // Contention goes to whoever did not own the bus last.
          w_own_d   = (w_req0 & w_req1) ? ~r_last : w_req1;
          w_qcnt_d  = '0;
          w_state_d = StOwn;
        end
      end
      StOwn: begin
        if (w_accept) begin
          w_qcnt_d = r_qcnt + 1'b1;
        end
        if (!w_own_req || (w_accept && r_qcnt == QcntW'(QUANTUM - 1))) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_pend_d == '0) begin
          w_last_d  = r_own;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state   <= StIdle;
      r_own     <= 1'b0;
      r_last    <= 1'b1;
      r_qcnt    <= '0;
      r_pend    <= '0;
      r_arb_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_own     <= w_own_d;
      r_last    <= w_last_d;
      r_qcnt    <= w_qcnt_d;
      r_pend    <= w_pend_d;
      r_arb_err <= r_arb_err | (s.readdatavalid & (r_pend == '0));
    end
  end

  assign s.address    = w_cmd_addr;
  assign s.read       = w_s_read;
  assign s.write      = w_s_write;
  assign s.writedata  = w_cmd_wdata;
  assign s.byteenable = w_cmd_be;

  assign m0.waitrequest   = w_wait0;
  assign m1.waitrequest   = w_wait1;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = w_rdv_ok & ~r_own;
  assign m1.readdatavalid = w_rdv_ok & r_own;

  assign arb_err = r_arb_err;

endmodule

// File: tb/tb_sdram_mm_arbiter.sv
// tb_sdram_mm_arbiter
//   Drives both masters from command queues, models the SDRAM slave with an
//   in-order return queue, and checks the arbiter against transaction-level
//   rules plus directed cycle sequences for the key scenarios.
module tb_sdram_mm_arbiter;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned QUANTUM  = 4;
  localparam int unsigned MAX_PEND = 2;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic arb_err;

  always #5 clk_clk = ~clk_clk;

  sdram_mm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_m0 ();
  sdram_mm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_m1 ();
  sdram_mm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_s ();

  sdram_mm_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUANTUM(QUANTUM), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .m0         (if_m0),
    .m1         (if_m1),
    .s          (if_s),
    .arb_err    (arb_err)
  );

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_t;

  // One accepted read still owed by the slave: due cycle, data, issuer.
  typedef struct packed {
    logic [31:0]       due;
    logic [DATA_W-1:0] data;
    logic              id;
  } ret_t;

  cmd_t q0[$];
  cmd_t q1[$];
  ret_t sq[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned lat_lo = 5, lat_hi = 5, wait_pct = 0;
  logic spur = 1'b0;
  logic err_model = 1'b0;
  logic [1:0] last_acc = 2'd2;  // 2 = no accept seen yet

  // Per-step observations for the directed checks.
  logic o_srd, o_swr, o_w0, o_w1, o_rdv0, o_rdv1, o_err;
  logic [ADDR_W-1:0] o_saddr;
  logic [1:0] o_acc;  // 0/1 = master accepted this cycle, 2 = none

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic rd, input int unsigned addr, input int unsigned data);
    cmd_t c;
    c.rd   = rd;
    c.addr = ADDR_W'(addr);
    c.data = DATA_W'(data);
    c.be   = BE_W'(data);
    return c;
  endfunction

  // One bus cycle: drive slave/master inputs, check the settled outputs
  // against the model, then advance to just after the next rising edge.
  task automatic step();
    logic rv, empty0, v0, v1, g0, g1, acc;
    ret_t r;
    cmd_t c0, c1, c;
    r      = '0;
    rv     = 1'b0;
    empty0 = (sq.size() == 0);
    if (!empty0 && sq[0].due <= 32'(cyc)) begin
      rv = 1'b1;
      r  = sq.pop_front();
    end
    if_s.readdatavalid = rv | spur;
    if_s.readdata      = rv ? r.data : DATA_W'($urandom());
    if_s.waitrequest   = ($urandom_range(0, 99) < wait_pct);
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    c0 = v0 ? q0[0] : '0;
    c1 = v1 ? q1[0] : '0;
    if_m0.read = v0 & c0.rd;  if_m0.write = v0 & ~c0.rd;
    if_m0.address = c0.addr;  if_m0.writedata = c0.data;  if_m0.byteenable = c0.be;
    if_m1.read = v1 & c1.rd;  if_m1.write = v1 & ~c1.rd;
    if_m1.address = c1.addr;  if_m1.writedata = c1.data;  if_m1.byteenable = c1.be;
    #2;
    o_srd = if_s.read;  o_swr = if_s.write;  o_saddr = if_s.address;
    o_w0 = if_m0.waitrequest;  o_w1 = if_m1.waitrequest;
    o_rdv0 = if_m0.readdatavalid;  o_rdv1 = if_m1.readdatavalid;
    o_err = arb_err;  o_acc = 2'd2;
    if (reset_reset) begin
      q0.delete();  q1.delete();  sq.delete();
      err_model = 1'b0;
      last_acc  = 2'd2;
    end else begin
      g0 = v0 & ~if_m0.waitrequest;
      g1 = v1 & ~if_m1.waitrequest;
      chk1("single_grant", g0 & g1, 1'b0);
      if (!if_s.waitrequest) chk1("accept", if_s.read | if_s.write, g0 | g1);
      chk1("rdv0", if_m0.readdatavalid, rv & ~r.id);
      chk1("rdv1", if_m1.readdatavalid, rv & r.id);
      if (rv) chkw("rdata", 64'(r.id ? if_m1.readdata : if_m0.readdata), 64'(r.data));
      chk1("arb_err", arb_err, err_model);
      if (spur & empty0) err_model = 1'b1;
      if (g0 | g1) begin
        c   = g0 ? c0 : c1;
        acc = g1;
        chk1("cmd_rd", if_s.read, c.rd);
        chk1("cmd_wr", if_s.write, ~c.rd);
        chkw("cmd_addr", 64'(if_s.address), 64'(c.addr));
        chkw("cmd_be", 64'(if_s.byteenable), 64'(c.be));
        if (!c.rd) chkw("cmd_wdata", 64'(if_s.writedata), 64'(c.data));
        if (last_acc != 2'd2 && {1'b0, acc} != last_acc)
          chkw("drained_before_switch", 64'(sq.size()), 64'd0);
        if (c.rd) begin
          sq.push_back('{due: 32'(cyc) + 32'($urandom_range(lat_lo, lat_hi)),
                         data: DATA_W'($urandom()), id: acc});
          chk1("pend_le_max", sq.size() <= int'(MAX_PEND), 1'b1);
        end
        if (g0) void'(q0.pop_front());
        else    void'(q1.pop_front());
        last_acc = {1'b0, acc};
        o_acc    = {1'b0, acc};
      end
    end
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  initial begin
    int exp_acc [15];
    logic exp_rdv0 [15];
    @(posedge clk_clk);
    #1;

    // Reset state
    reset_reset = 1'b1;
    step();
    step();
    reset_reset = 1'b0;
    step();
    chk1("rst_w0", o_w0, 1'b1);
    chk1("rst_w1", o_w1, 1'b1);
    chk1("rst_srd", o_srd, 1'b0);
    chk1("rst_swr", o_swr, 1'b0);
    chk1("rst_err", o_err, 1'b0);

    // m0 writes 4 words alone; first command visible one cycle after request
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 32'h10 + i, 32'hD000_0000 + i));
    step();
    chk1("t1_idle_swr", o_swr, 1'b0);
    chk1("t1_idle_w0", o_w0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chkw("t1_acc", 64'(o_acc), 64'd0);
      chkw("t1_addr", 64'(o_saddr), 64'h10 + 64'(i));
      chk1("t1_w1", o_w1, 1'b1);
    end
    step();
    chk1("t1_drain_swr", o_swr, 1'b0);
    step();

    // Both stream writes: 4-transfer tenures alternating, m1 first (m0 was last)
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(1'b0, 32'h100 + i, 32'hA000_0000 + i));
      q1.push_back(mk(1'b0, 32'h200 + i, 32'hB000_0000 + i));
    end
    for (int n = 0; n <= 24; n++) begin
      int e;
      step();
      if (n == 0) e = 2;
      else if ((n - 1) % 6 < 4) e = (((n - 1) / 6) % 2 == 0) ? 1 : 0;
      else e = 2;
      chkw("t2_owner", 64'(o_acc), 64'(e));
    end

    // m0 three reads, latency 5, window of 2; m1 waits for the last return
    exp_acc  = '{2, 0, 0, 2, 2, 2, 0, 2, 2, 2, 2, 2, 2, 1, 2};
    exp_rdv0 = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    lat_lo = 5;  lat_hi = 5;
    for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 32'h300 + i, 0));
    for (int n = 0; n < 15; n++) begin
      if (n == 1) q1.push_back(mk(1'b0, 32'h400, 32'hC0FF_EE00));
      step();
      chkw("t3_owner", 64'(o_acc), 64'(exp_acc[n]));
      chk1("t3_rdv0", o_rdv0, exp_rdv0[n]);
      chk1("t3_rdv1", o_rdv1, 1'b0);
      if (n >= 3 && n <= 5) chk1("t4_held", o_w0, 1'b1);
    end
    repeat (3) step();

    // Return with nothing outstanding
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk1("t5_rdv0", o_rdv0, 1'b0);
    chk1("t5_rdv1", o_rdv1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("t5_err_sticky", o_err, 1'b1);
    end

    // Reset in the middle of a tenure with two reads outstanding
    lat_lo = 10;  lat_hi = 10;
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, 32'h500 + i, 0));
    repeat (4) step();
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    step();
    chk1("t6_srd", o_srd, 1'b0);
    chk1("t6_swr", o_swr, 1'b0);
    chk1("t6_w0", o_w0, 1'b1);
    chk1("t6_w1", o_w1, 1'b1);
    chk1("t6_err", o_err, 1'b0);
    lat_lo = 5;  lat_hi = 5;
    for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 32'h600 + i, 0));
    step();
    step();
    chkw("t6_pend_clear_a", 64'(o_acc), 64'd0);
    step();
    chkw("t6_pend_clear_b", 64'(o_acc), 64'd0);
    repeat (15) step();

    // Random traffic: both masters, random slave stalls and latency
    lat_lo = 1;  lat_hi = 6;  wait_pct = 25;
    for (int n = 0; n < 3000; n++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), $urandom(), $urandom()));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), $urandom(), $urandom()));
      step();
    end
    repeat (60) step();
    chkw("final_q0_empty", 64'(q0.size()), 64'd0);
    chkw("final_q1_empty", 64'(q1.size()), 64'd0);
    chkw("final_pend_empty", 64'(sq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
